// File: rtl/sample_recorder_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sample_recorder_if : AC97 wrapper sample path (frame strobe, mic in, codec out)
// Rev 1.0
// ---------------------------------------------------------------------------
interface sample_recorder_if;
   logic       ready;
   logic [7:0] audio_in_data;
   logic [7:0] audio_out_data;

   // master = audio wrapper side, slave = recorder side
   modport master (output ready, output audio_in_data, input  audio_out_data);
   modport slave  (input  ready, input  audio_in_data, output audio_out_data);
endinterface
`default_nettype wire

// File: rtl/sample_recorder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sample_recorder : records the 48 kHz mic byte stream into RAM and replays it
// Rev 1.0
// ---------------------------------------------------------------------------
module sample_recorder #(
   parameter int ADDR_WIDTH = 16,
   parameter bit MONITOR    = 1'b1
) (
   input  wire                  clock_100mhz,
   input  wire                  reset,
   sample_recorder_if.slave     audio,
   input  wire                  record,
   input  wire                  play,
   input  wire                  stop,
   output logic                 recording,
   output logic                 playing,
   output logic                 mem_full,
   output logic [ADDR_WIDTH:0]  sample_count
);
   localparam logic [ADDR_WIDTH:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0] ONE        = {{ADDR_WIDTH{1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_RECORD   = 2'd1,
      S_PREFETCH = 2'd2,
      S_PLAY     = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_WIDTH:0] addr_q, addr_d;
   logic [ADDR_WIDTH:0] length_q, length_d;
   logic [ADDR_WIDTH:0] count_q, count_d;
   logic [7:0]          audio_out_q, audio_out_d;
   logic                mem_full_q, mem_full_d;
   logic                recording_q, recording_d;
   logic                playing_q, playing_d;
   logic                fetch_q, fetch_d;
   logic [ADDR_WIDTH:0] addr_inc;
   logic                mem_we;
   logic [7:0]          ram_rdata_q;

   logic [7:0] mem [0:(1 << ADDR_WIDTH) - 1];

   // Single port: the write address and the read address are both addr_q.
   always_ff @(posedge clock_100mhz) begin
      if (mem_we) begin
         mem[addr_q[ADDR_WIDTH-1:0]] <= audio.audio_in_data;
      end
      ram_rdata_q <= mem[addr_q[ADDR_WIDTH-1:0]];
   end

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      length_d    = length_q;
      audio_out_d = audio_out_q;
      mem_full_d  = mem_full_q;
      fetch_d     = 1'b0;
      mem_we      = 1'b0;
      addr_inc    = addr_q + ONE;

      case (state_q)
         S_IDLE: begin
            audio_out_d = 8'h00;
            if (record) begin
               state_d    = S_RECORD;
               addr_d     = '0;
               mem_full_d = 1'b0;
            end else if (play && (length_q != '0)) begin
               state_d = S_PREFETCH;
               addr_d  = '0;
            end
         end
         S_RECORD: begin
            if (audio.ready) begin
               mem_we      = 1'b1;
               addr_d      = addr_inc;
               audio_out_d = MONITOR ? audio.audio_in_data : 8'h00;
            end
            if (audio.ready && (addr_inc == FULL_COUNT)) begin
               length_d    = FULL_COUNT;
               mem_full_d  = 1'b1;
               state_d     = S_IDLE;
               audio_out_d = 8'h00;
            end else if (stop) begin
               length_d    = addr_d;
               state_d     = S_IDLE;
               audio_out_d = 8'h00;
            end
         end
         S_PREFETCH: begin
            // First cycle lets the RAM register mem[0]; second moves it to the output.
            audio_out_d = 8'h00;
            fetch_d     = ~fetch_q;
            if (fetch_q) begin
               audio_out_d = ram_rdata_q;
               state_d     = S_PLAY;
            end
         end
         S_PLAY: begin
            audio_out_d = ram_rdata_q;
            if (stop || (audio.ready && (addr_inc == length_q))) begin
               state_d     = S_IDLE;
               audio_out_d = 8'h00;
            end else if (audio.ready) begin
               addr_d = addr_inc;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      recording_d = (state_d == S_RECORD);
      playing_d   = (state_d == S_PREFETCH) || (state_d == S_PLAY);
      count_d     = (state_d == S_RECORD) ? addr_d : length_d;
   end

   always_ff @(posedge clock_100mhz) begin
      if (reset) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         length_q    <= '0;
         count_q     <= '0;
         audio_out_q <= 8'h00;
         mem_full_q  <= 1'b0;
         recording_q <= 1'b0;
         playing_q   <= 1'b0;
         fetch_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         length_q    <= length_d;
         count_q     <= count_d;
         audio_out_q <= audio_out_d;
         mem_full_q  <= mem_full_d;
         recording_q <= recording_d;
         playing_q   <= playing_d;
         fetch_q     <= fetch_d;
      end
   end

   assign audio.audio_out_data = audio_out_q;
   assign recording            = recording_q;
   assign playing              = playing_q;
   assign mem_full             = mem_full_q;
   assign sample_count         = count_q;
endmodule
`default_nettype wire

// File: tb/tb_sample_recorder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sample_recorder : scoreboard bench; expected codec byte per ready is queued
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_sample_recorder;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          record = 1'b0;
   logic          play = 1'b0;
   logic          stop = 1'b0;
   logic          recording, playing, mem_full;
   logic          recording_nm, playing_nm, mem_full_nm;
   logic [AW:0]   sample_count, sample_count_nm;

   int            n_checks = 0;
   int            n_fail = 0;
   logic [7:0]    exp_q [$];

   sample_recorder_if bus ();
   sample_recorder_if bus_nm ();

   assign bus_nm.ready         = bus.ready;
   assign bus_nm.audio_in_data = bus.audio_in_data;

   sample_recorder #(.ADDR_WIDTH(AW), .MONITOR(1'b1)) dut (
      .clock_100mhz (clk),
      .reset        (reset),
      .audio        (bus),
      .record       (record),
      .play         (play),
      .stop         (stop),
      .recording    (recording),
      .playing      (playing),
      .mem_full     (mem_full),
      .sample_count (sample_count)
   );

   sample_recorder #(.ADDR_WIDTH(AW), .MONITOR(1'b0)) dut_nm (
      .clock_100mhz (clk),
      .reset        (reset),
      .audio        (bus_nm),
      .record       (record),
      .play         (play),
      .stop         (stop),
      .recording    (recording_nm),
      .playing      (playing_nm),
      .mem_full     (mem_full_nm),
      .sample_count (sample_count_nm)
   );

   always #5 clk = ~clk;

   // The wrapper latches the codec byte on each ready; compare it against the queue.
   initial begin
      logic [7:0] e;
      forever begin
         @(negedge clk);
         if (bus.ready === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL ready_latch: unexpected ready, got %02h expected no ready", bus.audio_out_data);
            end else begin
               e = exp_q.pop_front();
               if (bus.audio_out_data !== e) begin
                  n_fail++;
                  $display("FAIL ready_latch @%0t: got %02h expected %02h", $time, bus.audio_out_data, e);
               end
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic pulse(input logic r, input logic p, input logic s);
      @(posedge clk); #1;
      record = r; play = p; stop = s;
      @(posedge clk); #1;
      record = 1'b0; play = 1'b0; stop = 1'b0;
   endtask

   // One AC97 frame: 19 quiet cycles then a ready, optionally with a coincident stop.
   task automatic frame(input logic [7:0] din, input logic [7:0] exp, input logic with_stop);
      repeat (19) @(posedge clk);
      #1;
      exp_q.push_back(exp);
      bus.ready = 1'b1;
      bus.audio_in_data = din;
      stop = with_stop;
      @(posedge clk); #1;
      bus.ready = 1'b0;
      stop = 1'b0;
   endtask

   initial begin
      bus.ready = 1'b0;
      bus.audio_in_data = 8'h00;

      // Reset and play with an empty clip
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      chk("rst_recording", recording, 0);
      chk("rst_playing", playing, 0);
      chk("rst_mem_full", mem_full, 0);
      chk("rst_count", sample_count, 0);
      chk("rst_out", bus.audio_out_data, 8'h00);
      pulse(1'b0, 1'b1, 1'b0);
      chk("empty_play_ignored", playing, 0);
      frame(8'h5A, 8'h00, 1'b0);
      chk("empty_play_still_idle", playing, 0);

      // Record five samples, stop, replay
      pulse(1'b1, 1'b0, 1'b0);
      chk("rec_entered", recording, 1);
      frame(8'h11, 8'h00, 1'b0);
      frame(8'h22, 8'h11, 1'b0);
      frame(8'h33, 8'h22, 1'b0);
      frame(8'h44, 8'h33, 1'b0);
      frame(8'h55, 8'h44, 1'b0);
      chk("rec_live_count", sample_count, 5);
      pulse(1'b0, 1'b0, 1'b1);
      chk("stop_recording", recording, 0);
      chk("stop_count", sample_count, 5);
      chk("stop_out", bus.audio_out_data, 8'h00);
      pulse(1'b0, 1'b1, 1'b0);
      chk("play_entered", playing, 1);
      frame(8'hA5, 8'h11, 1'b0);
      frame(8'hA5, 8'h22, 1'b0);
      frame(8'hA5, 8'h33, 1'b0);
      frame(8'hA5, 8'h44, 1'b0);
      frame(8'hA5, 8'h55, 1'b0);
      chk("play_end_playing", playing, 0);
      chk("play_end_out", bus.audio_out_data, 8'h00);
      frame(8'hA5, 8'h00, 1'b0);
      chk("play_end_count", sample_count, 5);

      // Fill the RAM
      pulse(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 16; i++) begin
         frame(8'(i), (i == 0) ? 8'h00 : 8'(i - 1), 1'b0);
      end
      chk("full_recording", recording, 0);
      chk("full_mem_full", mem_full, 1);
      chk("full_count", sample_count, 16);
      frame(8'hEE, 8'h00, 1'b0);
      chk("full_count_after_extra", sample_count, 16);
      pulse(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 16; i++) begin
         frame(8'hC3, 8'(i), 1'b0);
      end
      chk("full_play_done", playing, 0);
      frame(8'hC3, 8'h00, 1'b0);

      // Priority and coincident stops
      pulse(1'b1, 1'b1, 1'b0);
      chk("prio_recording", recording, 1);
      chk("prio_not_playing", playing, 0);
      chk("prio_mem_full_cleared", mem_full, 0);
      frame(8'hA1, 8'h00, 1'b0);
      frame(8'hA2, 8'hA1, 1'b0);
      frame(8'hA3, 8'hA2, 1'b1);
      chk("rec_stop_ready_count", sample_count, 3);
      chk("rec_stop_ready_recording", recording, 0);
      pulse(1'b0, 1'b1, 1'b0);
      frame(8'h00, 8'hA1, 1'b0);
      frame(8'h00, 8'hA2, 1'b1);
      chk("play_stop_ready_playing", playing, 0);
      chk("play_stop_ready_out", bus.audio_out_data, 8'h00);
      frame(8'h00, 8'h00, 1'b0);

      // Monitor echo and reset abort
      pulse(1'b1, 1'b0, 1'b0);
      frame(8'h7F, 8'h00, 1'b0);
      chk("monitor_on_out", bus.audio_out_data, 8'h7F);
      chk("monitor_off_out", bus_nm.audio_out_data, 8'h00);
      frame(8'h80, 8'h7F, 1'b0);
      pulse(1'b0, 1'b0, 1'b1);
      chk("two_count", sample_count, 2);
      pulse(1'b0, 1'b1, 1'b0);
      repeat (5) @(posedge clk);
      #1;
      chk("abort_pre_playing", playing, 1);
      chk("abort_pre_out", bus.audio_out_data, 8'h7F);
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      chk("abort_playing", playing, 0);
      chk("abort_count", sample_count, 0);
      chk("abort_out", bus.audio_out_data, 8'h00);
      pulse(1'b0, 1'b1, 1'b0);
      chk("abort_replay_ignored", playing, 0);
      frame(8'h33, 8'h00, 1'b0);

      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
